key_event_gen: RTL and testbench

Front-end for the push-button keys. Synchronises each raw key input, debounces it, and turns it into clean single-cycle press, release, short-press and long-press events. The display/state logic runs on a clock and consumes these events instead of sampling raw key edges. One instance serves all board keys.

---
 rtl/key_event_gen_if.sv | 37 +++
 rtl/key_event_gen.sv | 120 ++++++++++++
 tb/tb_key_event_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
// key_event_gen_if
// Bundles the raw key pins and the event outputs of key_event_gen.
//   key_in        : raw key pins, 0 = pressed (driven by the board/master side)
//   key_level     : debounced level, 1 = pressed
//   press_pulse   : 1-cycle pulse on accepted press
//   release_pulse : 1-cycle pulse on accepted release
//   short_pulse   : 1-cycle pulse on release of a press that never went long
//   long_pulse    : 1-cycle pulse when the hold time reaches the long threshold
// The slave modport is the key_event_gen side; master is the pin/consumer side.
interface key_event_gen_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] short_pulse;
    logic [NUM_KEYS-1:0] long_pulse;

    modport master (
        output key_in,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  short_pulse,
        input  long_pulse
    );

    modport slave (
        input  key_in,
        output key_level,
        output press_pulse,
        output release_pulse,
        output short_pulse,
        output long_pulse
    );
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen
// Push-button front end: per key, a 2-flop synchroniser, a stability-counter
// debouncer and a small press/hold FSM that emit registered single-cycle
// press, release, short-press and long-press events.
//   clk   : system clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   kif   : key_event_gen_if slave (key_in in; key_level and pulses out)
// Parameters:
//   NUM_KEYS    : number of independent key channels
//   DEB_CYCLES  : stable cycles needed to accept a level change (>= 2)
//   LONG_CYCLES : hold cycles before a long event (> DEB_CYCLES)
module key_event_gen #(
    parameter int NUM_KEYS    = 2,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            rst_n,
    key_event_gen_if.slave  kif
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] LONG = 2'd2;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic          sync1;
        logic          sync_n;
        logic [CW-1:0] cnt;
        logic          level;
        logic [1:0]    state;
        logic [HW-1:0] hold;
        logic          press_q;
        logic          release_q;
        logic          short_q;
        logic          long_q;
        logic          differ;
        logic          accept;

        // sync_n is active-low; compare its pressed sense with the debounced level
        assign differ = (~sync_n) != level;
        // accept is the cycle the level flips; the FSM reacts on the same edge so
        // the pulse lines up with the key_level change
        assign accept = differ && (cnt == DEB_MAX);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1     <= 1'b1;
                sync_n    <= 1'b1;
                cnt       <= '0;
                level     <= 1'b0;
                state     <= IDLE;
                hold      <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync1  <= kif.key_in[i];
                sync_n <= sync1;

                if (!differ) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt   <= '0;
                    level <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                press_q   <= 1'b0;
                release_q <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;

                case (state)
                    IDLE: begin
                        if (accept) begin
                            state   <= HELD;
                            press_q <= 1'b1;
                            hold    <= '0;
                        end
                    end
                    HELD: begin
                        // release takes priority over a long threshold on the same edge
                        if (accept) begin
                            state     <= IDLE;
                            release_q <= 1'b1;
                            short_q   <= 1'b1;
                        end else if (hold == LONG_MAX) begin
                            state  <= LONG;
                            long_q <= 1'b1;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                    LONG: begin
                        if (accept) begin
                            state     <= IDLE;
                            release_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign kif.key_level[i]     = level;
        assign kif.press_pulse[i]   = press_q;
        assign kif.release_pulse[i] = release_q;
        assign kif.short_pulse[i]   = short_q;
        assign kif.long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

    localparam int NK   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    key_event_gen_if #(.NUM_KEYS(NK)) kif ();

    key_event_gen #(
        .NUM_KEYS    (NK),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic p;
        logic r;
        logic s;
        logic l;
        logic lvl;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic expect_ev(input int ch, input int c, input logic p, input logic r,
                             input logic s, input logic l, input logic lvl);
        exp_t e;
        e.cyc = c; e.p = p; e.r = r; e.s = s; e.l = l; e.lvl = lvl;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Monitor: whenever a channel shows any pulse, pop its next expected event.
    always @(negedge clk) begin
        logic p, r, s, l, lvl, empty;
        exp_t e;
        for (int ch = 0; ch < NK; ch++) begin
            p   = kif.press_pulse[ch];
            r   = kif.release_pulse[ch];
            s   = kif.short_pulse[ch];
            l   = kif.long_pulse[ch];
            lvl = kif.key_level[ch];
            if (p | r | s | l) begin
                tests++;
                empty = (ch == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    fails++;
                    $display("FAIL unexpected_ch%0d cyc=%0d got p%b r%b s%b l%b required no event",
                             ch, cyc, p, r, s, l);
                end else begin
                    if (ch == 0) e = q0.pop_front();
                    else         e = q1.pop_front();
                    if (e.cyc != cyc || e.p !== p || e.r !== r || e.s !== s ||
                        e.l !== l || e.lvl !== lvl) begin
                        fails++;
                        $display("FAIL event_ch%0d got cyc=%0d p%b r%b s%b l%b lvl%b required cyc=%0d p%b r%b s%b l%b lvl%b",
                                 ch, cyc, p, r, s, l, lvl, e.cyc, e.p, e.r, e.s, e.l, e.lvl);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [9:0] all_out();
        return {kif.key_level, kif.press_pulse, kif.release_pulse,
                kif.short_pulse, kif.long_pulse};
    endfunction

    // Advance to the falling edge where cyc == c; a change made there is
    // first sampled on edge c+1.
    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        kif.key_in = 2'b00;
        rst_n      = 1'b0;

        // Reset with both keys low: outputs stay 0, then both presses accepted.
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            at(i);
            check($sformatf("reset_outputs_c%0d", i), 32'(all_out()), 32'h0);
        end
        rst_n = 1'b1;                     // first sample edge 4
        expect_ev(0, 9, 1, 0, 0, 0, 1);
        expect_ev(1, 9, 1, 0, 0, 0, 1);
        at(11); kif.key_in = 2'b11;       // sample 12
        expect_ev(0, 17, 0, 1, 1, 0, 0);
        expect_ev(1, 17, 0, 1, 1, 0, 0);

        // Short press on key0.
        at(24); kif.key_in[0] = 1'b0;     // sample 25
        expect_ev(0, 30, 1, 0, 0, 0, 1);
        at(32); check("short_level_held", 32'(kif.key_level), 32'h1);
        at(34); kif.key_in[0] = 1'b1;     // sample 35
        expect_ev(0, 40, 0, 1, 1, 0, 0);

        // Bounce on key0: 2-cycle runs never reach the debounce count.
        for (int k = 0; k < 10; k++) begin
            at(49 + 2 * k);
            kif.key_in[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
        end
        at(69); kif.key_in[0] = 1'b1;
        at(80); check("bounce_level", 32'(kif.key_level), 32'h0);

        // Long press on key1: long 16 cycles after press, release only.
        at(89); kif.key_in[1] = 1'b0;     // sample 90
        expect_ev(1, 95, 1, 0, 0, 0, 1);
        expect_ev(1, 111, 0, 0, 0, 1, 1);
        at(129); kif.key_in[1] = 1'b1;    // sample 130
        expect_ev(1, 135, 0, 1, 0, 0, 0);

        // Independence: overlapping activity on both channels.
        at(149); kif.key_in[1] = 1'b0;    // sample 150
        expect_ev(1, 155, 1, 0, 0, 0, 1);
        at(152); kif.key_in[0] = 1'b0;    // sample 153
        expect_ev(0, 158, 1, 0, 0, 0, 1);
        at(159); kif.key_in[1] = 1'b1;    // sample 160
        expect_ev(1, 165, 0, 1, 1, 0, 0);
        expect_ev(0, 174, 0, 0, 0, 1, 1);
        at(182); kif.key_in[0] = 1'b1;    // sample 183
        expect_ev(0, 188, 0, 1, 0, 0, 0);

        // Release lands exactly on the long threshold: release wins.
        at(199); kif.key_in[0] = 1'b0;    // sample 200
        expect_ev(0, 205, 1, 0, 0, 0, 1);
        at(210); check("boundary_level_held", 32'(kif.key_level), 32'h1);
        at(215); kif.key_in[0] = 1'b1;    // sample 216
        expect_ev(0, 221, 0, 1, 1, 0, 0);

        // Reset while key0 is held: everything clears, no release events.
        at(239); kif.key_in[0] = 1'b0;    // sample 240
        expect_ev(0, 245, 1, 0, 0, 0, 1);
        at(250); rst_n = 1'b0; kif.key_in = 2'b11;
        at(251); check("midhold_reset_outputs", 32'(all_out()), 32'h0);
        at(252); rst_n = 1'b1;
        at(280); check("after_reset_level", 32'(kif.key_level), 32'h0);

        at(290);
        check("pending_ch0", 32'(q0.size()), 32'h0);
        check("pending_ch1", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
